// File: rtl/vote_window_fsm.sv
// rtl/vote_window_fsm.sv - timed M-of-N ballot window with optional early decision
module vote_window_fsm #(
  parameter int N       = 4,
  parameter int THRESH  = 3,
  parameter int WIN_CYC = 16,
  parameter int CNT_W   = 3,
  parameter int EARLY   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [N-1:0]     vote_yes,
  input  logic [N-1:0]     vote_no,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] yes_cnt,
  output logic [N-1:0]     voted
);

  // Timer counts down from WIN_CYC-1; a window of one cycle still needs a 1-bit timer.
  localparam int                   TIMER_W    = (WIN_CYC > 1) ? $clog2(WIN_CYC) : 1;
  localparam logic [TIMER_W-1:0]   TIMER_LOAD = TIMER_W'(WIN_CYC - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_VOTE   = 2'd1,
    ST_DECIDE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [N-1:0]       voted_q, voted_d;
  logic [N-1:0]       yes_mask_q, yes_mask_d;
  logic [CNT_W-1:0]   yes_cnt_q, yes_cnt_d;
  logic               pass_q, pass_d;
  logic               done_q, done_d;

  logic [N-1:0]       new_no;
  logic [N-1:0]       new_yes;
  logic [CNT_W-1:0]   new_yes_cnt;
  int                 voted_cnt;
  logic               all_voted;
  logic               reached;
  logic               unreachable;
  logic               window_end;

  // Classify this cycle's ballots from voters that have not yet voted; no wins over yes.
  always_comb begin
    new_no      = '0;
    new_yes     = '0;
    new_yes_cnt = '0;
    voted_cnt   = 0;
    for (int i = 0; i < N; i++) begin
      if (voted_q[i]) begin
        voted_cnt = voted_cnt + 1;
      end else if (vote_no[i]) begin
        new_no[i] = 1'b1;
      end else if (vote_yes[i]) begin
        new_yes[i]  = 1'b1;
        new_yes_cnt = new_yes_cnt + CNT_W'(1);
      end
    end
  end

  // Window-end conditions, judged only on registered tallies so the exit cycle is well defined.
  always_comb begin
    all_voted   = &voted_q;
    reached     = int'(yes_cnt_q) >= THRESH;
    unreachable = (int'(yes_cnt_q) + (N - voted_cnt)) < THRESH;
    window_end  = (timer_q == '0) || all_voted ||
                  ((EARLY != 0) && (reached || unreachable));
  end

  // Next-state and datapath updates for the IDLE -> VOTE -> DECIDE -> IDLE sequence.
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    voted_d    = voted_q;
    yes_mask_d = yes_mask_q;
    yes_cnt_d  = yes_cnt_q;
    pass_d     = pass_q;
    done_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          voted_d    = '0;
          yes_mask_d = '0;
          yes_cnt_d  = '0;
          pass_d     = 1'b0;
          timer_d    = TIMER_LOAD;
          state_d    = ST_VOTE;
        end
      end
      ST_VOTE: begin
        // Ballots arriving in the exit cycle are still recorded.
        voted_d    = voted_q | new_no | new_yes;
        yes_mask_d = yes_mask_q | new_yes;
        yes_cnt_d  = yes_cnt_q + new_yes_cnt;
        if (window_end) begin
          state_d = ST_DECIDE;
        end else begin
          timer_d = timer_q - TIMER_W'(1);
        end
      end
      ST_DECIDE: begin
        pass_d  = reached;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any window without a done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      timer_q    <= '0;
      voted_q    <= '0;
      yes_mask_q <= '0;
      yes_cnt_q  <= '0;
      pass_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      voted_q    <= voted_d;
      yes_mask_q <= yes_mask_d;
      yes_cnt_q  <= yes_cnt_d;
      pass_q     <= pass_d;
      done_q     <= done_d;
    end
  end

  assign busy    = (state_q != ST_IDLE);
  assign done    = done_q;
  assign pass    = pass_q;
  assign yes_cnt = yes_cnt_q;
  assign voted   = voted_q;

endmodule

// File: tb/tb_vote_window_fsm.sv
// tb/tb_vote_window_fsm.sv - directed bench for vote_window_fsm with rule-level reference model
module tb_vote_window_fsm;

  localparam int NV  = 4;
  localparam int WIN = 16;
  // Four instances share stimulus: A=3/early, B=3/no-early, C=thresh 0, D=thresh above N.
  localparam int TH [4] = '{3, 3, 0, 5};
  localparam int EA [4] = '{1, 0, 1, 1};

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic [3:0] vote_yes = 4'd0;
  logic [3:0] vote_no  = 4'd0;

  logic [3:0]      busy_o;
  logic [3:0]      done_o;
  logic [3:0]      pass_o;
  logic [3:0][2:0] ycnt_o;
  logic [3:0][3:0] vt_o;

  int checks = 0;
  int errors = 0;

  // reference model state per instance
  bit m_busy [4];
  bit m_dec  [4];
  bit m_pass [4];
  bit m_done [4];
  int m_age  [4];
  int m_yes  [4];
  bit m_v    [4][4];

  always #5 clk = ~clk;

  vote_window_fsm #(.N(4), .THRESH(3), .WIN_CYC(16), .CNT_W(3), .EARLY(1)) u_a (
    .clk(clk), .rst(rst), .start(start), .vote_yes(vote_yes), .vote_no(vote_no),
    .busy(busy_o[0]), .done(done_o[0]), .pass(pass_o[0]), .yes_cnt(ycnt_o[0]), .voted(vt_o[0]));
  vote_window_fsm #(.N(4), .THRESH(3), .WIN_CYC(16), .CNT_W(3), .EARLY(0)) u_b (
    .clk(clk), .rst(rst), .start(start), .vote_yes(vote_yes), .vote_no(vote_no),
    .busy(busy_o[1]), .done(done_o[1]), .pass(pass_o[1]), .yes_cnt(ycnt_o[1]), .voted(vt_o[1]));
  vote_window_fsm #(.N(4), .THRESH(0), .WIN_CYC(16), .CNT_W(3), .EARLY(1)) u_c (
    .clk(clk), .rst(rst), .start(start), .vote_yes(vote_yes), .vote_no(vote_no),
    .busy(busy_o[2]), .done(done_o[2]), .pass(pass_o[2]), .yes_cnt(ycnt_o[2]), .voted(vt_o[2]));
  vote_window_fsm #(.N(4), .THRESH(5), .WIN_CYC(16), .CNT_W(3), .EARLY(1)) u_d (
    .clk(clk), .rst(rst), .start(start), .vote_yes(vote_yes), .vote_no(vote_no),
    .busy(busy_o[3]), .done(done_o[3]), .pass(pass_o[3]), .yes_cnt(ycnt_o[3]), .voted(vt_o[3]));

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_out(string nm, int k, logic b, logic d, logic p, int y, logic [3:0] v);
    check({nm, "_busy"}, 32'(busy_o[k]), 32'(b));
    check({nm, "_done"}, 32'(done_o[k]), 32'(d));
    check({nm, "_pass"}, 32'(pass_o[k]), 32'(p));
    check({nm, "_ycnt"}, 32'(ycnt_o[k]), 32'(y));
    check({nm, "_voted"}, 32'(vt_o[k]), 32'(v));
  endtask

  task automatic tick(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One clock of the voting rules for instance k, from the ballots presented this cycle.
  task automatic model_step(int k);
    int nv = 0;
    bit ex;
    for (int i = 0; i < NV; i++) nv += int'(m_v[k][i]);
    if (m_dec[k]) begin
      m_pass[k] = (m_yes[k] >= TH[k]);
      m_done[k] = 1'b1;
      m_dec[k]  = 1'b0;
      m_busy[k] = 1'b0;
    end else if (m_busy[k]) begin
      m_done[k] = 1'b0;
      ex = (m_age[k] + 1 >= WIN) || (nv == NV) ||
           ((EA[k] != 0) && ((m_yes[k] >= TH[k]) || (m_yes[k] + (NV - nv) < TH[k])));
      for (int i = 0; i < NV; i++) begin
        if (!m_v[k][i]) begin
          if (vote_no[i]) m_v[k][i] = 1'b1;
          else if (vote_yes[i]) begin
            m_v[k][i] = 1'b1;
            m_yes[k]++;
          end
        end
      end
      if (ex) m_dec[k] = 1'b1;
      else m_age[k]++;
    end else begin
      m_done[k] = 1'b0;
      if (start) begin
        for (int i = 0; i < NV; i++) m_v[k][i] = 1'b0;
        m_yes[k]  = 0;
        m_pass[k] = 1'b0;
        m_age[k]  = 0;
        m_busy[k] = 1'b1;
      end
    end
  endtask

  // Advance the reference model on each clock; reset clears it immediately.
  always @(posedge clk or posedge rst) begin
    for (int k = 0; k < 4; k++) begin
      if (rst) begin
        m_busy[k] = 1'b0;
        m_dec[k]  = 1'b0;
        m_pass[k] = 1'b0;
        m_done[k] = 1'b0;
        m_age[k]  = 0;
        m_yes[k]  = 0;
        for (int i = 0; i < NV; i++) m_v[k][i] = 1'b0;
      end else begin
        model_step(k);
      end
    end
  end

  // Compare every instance against the model on each falling edge.
  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) begin
      logic [3:0] mv;
      for (int i = 0; i < NV; i++) mv[i] = m_v[k][i];
      check($sformatf("cmp%0d_busy", k), 32'(busy_o[k]), 32'(m_busy[k]));
      check($sformatf("cmp%0d_done", k), 32'(done_o[k]), 32'(m_done[k]));
      check($sformatf("cmp%0d_pass", k), 32'(pass_o[k]), 32'(m_pass[k]));
      check($sformatf("cmp%0d_ycnt", k), 32'(ycnt_o[k]), 32'(m_yes[k]));
      check($sformatf("cmp%0d_voted", k), 32'(vt_o[k]), 32'(mv));
    end
  end

  initial begin
    #1 rst = 1'b1;
    #10;
    for (int k = 0; k < 4; k++) chk_out("reset", k, 0, 0, 0, 0, 4'b0000);
    #1 rst = 1'b0;
    tick(2);

    // 1: three yes at cycle 2 -> done at 5; C/D decide at once on boundary thresholds
    start = 1'b1;
    tick; start = 1'b0;
    tick; vote_yes = 4'b0111;
    tick; vote_yes = 4'b0000;
    chk_out("t1_c", 2, 0, 1, 1, 0, 4'b0000);
    chk_out("t1_d", 3, 0, 1, 0, 0, 4'b0000);
    check("t1_a_busy3", 32'(busy_o[0]), 32'd1);
    tick;
    check("t1_a_busy4", 32'(busy_o[0]), 32'd1);
    check("t1_a_done4", 32'(done_o[0]), 32'd0);
    tick;
    chk_out("t1_a5", 0, 0, 1, 1, 3, 4'b0111);
    tick;
    chk_out("t1_a6", 0, 0, 0, 1, 3, 4'b0111);
    tick(20);

    // 2: two no at cycle 1 -> early fail, done at 4
    start = 1'b1;
    tick; start = 1'b0; vote_no = 4'b0011;
    tick; vote_no = 4'b0000;
    tick;
    check("t2_a_done3", 32'(done_o[0]), 32'd0);
    tick;
    chk_out("t2_a4", 0, 0, 1, 0, 0, 4'b0011);
    tick(20);

    // 3: single yes at cycle 3 -> timeout, done at 18
    start = 1'b1;
    tick; start = 1'b0;
    tick;
    tick; vote_yes = 4'b0001;
    tick; vote_yes = 4'b0000;
    tick(13);
    chk_out("t3_a17", 0, 1, 0, 0, 1, 4'b0001);
    tick;
    chk_out("t3_a18", 0, 0, 1, 0, 1, 4'b0001);
    tick(5);

    // 3b: EARLY=0 instance, all yes at cycle 1 -> all-voted exit, done at 4
    start = 1'b1;
    tick; start = 1'b0; vote_yes = 4'b1111;
    tick; vote_yes = 4'b0000;
    tick;
    check("t3b_b_done3", 32'(done_o[1]), 32'd0);
    tick;
    chk_out("t3b_b4", 1, 0, 1, 1, 4, 4'b1111);
    tick(20);

    // 4: repeat and conflicting ballots
    start = 1'b1;
    tick; start = 1'b0; vote_yes = 4'b0001;
    tick; vote_yes = 4'b0010; vote_no = 4'b0011;
    tick; vote_yes = 4'b0000; vote_no = 4'b0000;
    chk_out("t4_a3", 0, 1, 0, 0, 1, 4'b0011);
    tick(15);
    chk_out("t4_a18", 0, 0, 1, 0, 1, 4'b0011);
    tick(5);

    // 5: reset mid-window, then a fresh window
    start = 1'b1;
    tick; start = 1'b0; vote_yes = 4'b0011;
    tick; vote_yes = 4'b0000;
    tick(3);
    chk_out("t5_a5", 0, 1, 0, 0, 2, 4'b0011);
    rst = 1'b1;
    #1;
    chk_out("t5_rst", 0, 0, 0, 0, 0, 4'b0000);
    #2 rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick;
      check("t5_no_done", 32'(done_o[0]), 32'd0);
    end
    start = 1'b1;
    tick; start = 1'b0; vote_yes = 4'b1111;
    tick; vote_yes = 4'b0000;
    tick(2);
    chk_out("t5_a4", 0, 0, 1, 1, 4, 4'b1111);
    tick(20);

    // 6: start held high; ignored while busy, accepted in the done cycle
    start = 1'b1;
    tick;
    tick; vote_yes = 4'b0111;
    tick; vote_yes = 4'b0000;
    tick;
    tick;
    chk_out("t6_a5", 0, 0, 1, 1, 3, 4'b0111);
    tick; start = 1'b0;
    chk_out("t6_a6", 0, 1, 0, 0, 0, 4'b0000);
    tick(40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
